// File: rtl/period_meter.sv
// Measures period and high time of an asynchronous square wave in clk cycles,
// with a one-cycle valid strobe per completed period and a loss-of-signal timeout.
module period_meter #(
   parameter int unsigned      WIDTH   = 32,
   parameter logic [WIDTH-1:0] TIMEOUT = WIDTH'(32'd200000000)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sig_in,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_cnt,
   output logic             meas_valid,
   output logic             timeout,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t           state, state_next;
   logic             s1, s2, s3;
   logic             rise, fall, at_max;
   logic [WIDTH-1:0] cnt, cnt_next, cnt_inc;
   logic [WIDTH-1:0] h_lat, h_lat_next;
   logic [WIDTH-1:0] period_next, high_next;
   logic             valid_next, timeout_next;

   assign rise    = s2 & ~s3;
   assign fall    = ~s2 & s3;
   assign at_max  = (cnt == TIMEOUT);
   // Saturating increment keeps cnt from passing TIMEOUT when an edge wins at the limit.
   assign cnt_inc = at_max ? cnt : cnt + 1'b1;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (rise) state_next = HIGH;
         HIGH: begin
            if (fall)        state_next = LOW;
            else if (at_max) state_next = IDLE;
         end
         LOW: begin
            if (rise)        state_next = HIGH;
            else if (at_max) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Edges take priority over the timeout check in both active states.
   always_comb begin
      cnt_next     = cnt;
      h_lat_next   = h_lat;
      period_next  = period;
      high_next    = high_cnt;
      valid_next   = 1'b0;
      timeout_next = timeout;
      case (state)
         IDLE: cnt_next = rise ? WIDTH'(1) : '0;
         HIGH: begin
            if (fall) begin
               h_lat_next = cnt;
               cnt_next   = cnt_inc;
            end else if (at_max) begin
               cnt_next     = '0;
               timeout_next = 1'b1;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         LOW: begin
            if (rise) begin
               cnt_next     = WIDTH'(1);
               period_next  = cnt;
               high_next    = h_lat;
               valid_next   = 1'b1;
               timeout_next = 1'b0;
            end else if (at_max) begin
               cnt_next     = '0;
               timeout_next = 1'b1;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         default: cnt_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1         <= 1'b0;
         s2         <= 1'b0;
         s3         <= 1'b0;
         cnt        <= '0;
         h_lat      <= '0;
         period     <= '0;
         high_cnt   <= '0;
         meas_valid <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         s1         <= sig_in;
         s2         <= s1;
         s3         <= s2;
         cnt        <= cnt_next;
         h_lat      <= h_lat_next;
         period     <= period_next;
         high_cnt   <= high_next;
         meas_valid <= valid_next;
         timeout    <= timeout_next;
      end
   end

endmodule
